// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decode-stage fields, resolves the ALU
// control code, and supports stall (hold) and flush (bubble) requests.
module id_ex_reg #(
  parameter int unsigned REG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 id_valid,
  input  logic [REG_WIDTH-1:0] id_pc,
  input  logic [REG_WIDTH-1:0] id_rs1_data,
  input  logic [REG_WIDTH-1:0] id_rs2_data,
  input  logic [REG_WIDTH-1:0] id_imm,
  input  logic [4:0]           id_rd,
  input  logic [2:0]           id_funct3,
  input  logic                 id_funct7_b5,
  input  logic [1:0]           id_alu_op,
  input  logic                 id_alu_src,
  input  logic                 id_reg_write,
  input  logic                 id_mem_read,
  input  logic                 id_mem_write,
  input  logic                 id_mem_to_reg,
  input  logic                 id_branch,
  output logic                 ex_valid,
  output logic [REG_WIDTH-1:0] ex_pc,
  output logic [REG_WIDTH-1:0] ex_in1,
  output logic [REG_WIDTH-1:0] ex_in2,
  output logic [REG_WIDTH-1:0] ex_store_data,
  output logic [4:0]           ex_rd,
  output logic [2:0]           ex_funct3,
  output logic [3:0]           ex_alu_control,
  output logic                 ex_illegal,
  output logic                 ex_reg_write,
  output logic                 ex_mem_read,
  output logic                 ex_mem_write,
  output logic                 ex_mem_to_reg,
  output logic                 ex_branch
);

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_XOR = 4'b0011,
    ALU_SUB = 4'b0110,
    ALU_SLL = 4'b0111,
    ALU_SRL = 4'b1000,
    ALU_SRA = 4'b1001
  } alu_ctrl_e;

  alu_ctrl_e alu_ctrl;
  logic      illegal;

  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    case (id_alu_op)
      2'b00: alu_ctrl = ALU_ADD;
      2'b01: alu_ctrl = ALU_SUB;
      default: begin
        // alu_op[0] marks I-type, which has no SUBI form
        case (id_funct3)
          3'b000:  alu_ctrl = (id_funct7_b5 && !id_alu_op[0]) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = id_funct7_b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          default: begin
            alu_ctrl = ALU_ADD;
            illegal  = 1'b1;
          end
        endcase
      end
    endcase
  end

  // Reset and flush both produce an all-zero bubble; both outrank stall.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ex_valid       <= 1'b0;
      ex_pc          <= '0;
      ex_in1         <= '0;
      ex_in2         <= '0;
      ex_store_data  <= '0;
      ex_rd          <= '0;
      ex_funct3      <= '0;
      ex_alu_control <= '0;
      ex_illegal     <= 1'b0;
      ex_reg_write   <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_mem_to_reg  <= 1'b0;
      ex_branch      <= 1'b0;
    end else if (!stall) begin
      ex_valid       <= id_valid;
      ex_pc          <= id_pc;
      ex_in1         <= id_rs1_data;
      ex_in2         <= id_alu_src ? id_imm : id_rs2_data;
      ex_store_data  <= id_rs2_data;
      ex_rd          <= id_rd;
      ex_funct3      <= id_funct3;
      ex_alu_control <= alu_ctrl;
      ex_illegal     <= illegal       && id_valid;
      ex_reg_write   <= id_reg_write  && id_valid;
      ex_mem_read    <= id_mem_read   && id_valid;
      ex_mem_write   <= id_mem_write  && id_valid;
      ex_mem_to_reg  <= id_mem_to_reg && id_valid;
      ex_branch      <= id_branch     && id_valid;
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// Randomized self-checking bench for id_ex_reg against a table-driven
// reference model of the pipeline register.
module tb_id_ex_reg;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset, stall, flush, id_valid;
  logic [W-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0] id_rd;
  logic [2:0] id_funct3;
  logic id_funct7_b5, id_alu_src;
  logic [1:0] id_alu_op;
  logic id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;

  logic ex_valid, ex_illegal;
  logic [W-1:0] ex_pc, ex_in1, ex_in2, ex_store_data;
  logic [4:0] ex_rd;
  logic [2:0] ex_funct3;
  logic [3:0] ex_alu_control;
  logic ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_reg #(.REG_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rd(id_rd),
    .id_funct3(id_funct3), .id_funct7_b5(id_funct7_b5), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_in1(ex_in1), .ex_in2(ex_in2),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_alu_control(ex_alu_control), .ex_illegal(ex_illegal),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch)
  );

  typedef struct {
    logic         valid;
    logic [W-1:0] pc, in1, in2, sd;
    logic [4:0]   rd;
    logic [2:0]   f3;
    logic [3:0]   alu;
    logic         ill, rw, mr, mw, m2r, br;
  } exp_t;

  exp_t m;

  // Base ALU code per funct3 for register/immediate ops
  localparam logic [3:0] FTAB [8] = '{4'h2, 4'h7, 4'h2, 4'h2, 4'h3, 4'h8, 4'h1, 4'h0};

  function automatic exp_t bubble();
    exp_t b;
    b.valid = 0; b.pc = 0; b.in1 = 0; b.in2 = 0; b.sd = 0; b.rd = 0; b.f3 = 0;
    b.alu = 0; b.ill = 0; b.rw = 0; b.mr = 0; b.mw = 0; b.m2r = 0; b.br = 0;
    return b;
  endfunction

  function automatic exp_t load();
    exp_t e;
    logic [3:0] a;
    logic bad;
    bad = id_alu_op[1] && (id_funct3 == 3'd2 || id_funct3 == 3'd3);
    if (id_alu_op == 2'd0)      a = 4'h2;
    else if (id_alu_op == 2'd1) a = 4'h6;
    else begin
      a = FTAB[id_funct3];
      if (id_funct7_b5 && id_funct3 == 3'd0 && id_alu_op == 2'd2) a = 4'h6;
      if (id_funct7_b5 && id_funct3 == 3'd5) a = 4'h9;
    end
    e.valid = id_valid; e.pc = id_pc; e.in1 = id_rs1_data;
    e.in2 = id_alu_src ? id_imm : id_rs2_data; e.sd = id_rs2_data;
    e.rd = id_rd; e.f3 = id_funct3; e.alu = a;
    e.ill = bad & id_valid; e.rw = id_reg_write & id_valid;
    e.mr = id_mem_read & id_valid; e.mw = id_mem_write & id_valid;
    e.m2r = id_mem_to_reg & id_valid; e.br = id_branch & id_valid;
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("valid", 64'(ex_valid), 64'(m.valid));
    check("pc", 64'(ex_pc), 64'(m.pc));
    check("in1", 64'(ex_in1), 64'(m.in1));
    check("in2", 64'(ex_in2), 64'(m.in2));
    check("store", 64'(ex_store_data), 64'(m.sd));
    check("rd", 64'(ex_rd), 64'(m.rd));
    check("funct3", 64'(ex_funct3), 64'(m.f3));
    check("alu", 64'(ex_alu_control), 64'(m.alu));
    check("illegal", 64'(ex_illegal), 64'(m.ill));
    check("reg_write", 64'(ex_reg_write), 64'(m.rw));
    check("mem_read", 64'(ex_mem_read), 64'(m.mr));
    check("mem_write", 64'(ex_mem_write), 64'(m.mw));
    check("mem_to_reg", 64'(ex_mem_to_reg), 64'(m.m2r));
    check("branch", 64'(ex_branch), 64'(m.br));
  endtask

  // One clock: model follows reset > flush > stall > load, then compare.
  task automatic step();
    @(posedge clk);
    if (reset || flush) m = bubble();
    else if (!stall)    m = load();
    #1;
    check_all();
  endtask

  task automatic rand_id();
    id_valid = 1'($urandom); id_pc = $urandom; id_rs1_data = $urandom;
    id_rs2_data = $urandom; id_imm = $urandom; id_rd = 5'($urandom);
    id_funct3 = 3'($urandom); id_funct7_b5 = 1'($urandom);
    id_alu_op = 2'($urandom); id_alu_src = 1'($urandom);
    id_reg_write = 1'($urandom); id_mem_read = 1'($urandom);
    id_mem_write = 1'($urandom); id_mem_to_reg = 1'($urandom);
    id_branch = 1'($urandom);
  endtask

  initial begin
    m = bubble();
    reset = 1; stall = 0; flush = 0;
    rand_id();
    id_valid = 1; id_reg_write = 1;
    step();
    step();
    reset = 0;

    // R-type SUB
    rand_id();
    id_valid = 1; id_alu_op = 2'b10; id_funct3 = 3'b000; id_funct7_b5 = 1;
    id_alu_src = 0; id_rs1_data = 32'h0A; id_rs2_data = 32'h03;
    step();
    check("rsub_alu", 64'(ex_alu_control), 64'h6);
    check("rsub_in2", 64'(ex_in2), 64'h3);
    check("rsub_valid", 64'(ex_valid), 64'h1);

    // I-type SRAI, then funct3=000 with funct7_b5 (no SUBI)
    id_alu_op = 2'b11; id_funct3 = 3'b101; id_funct7_b5 = 1; id_alu_src = 1;
    id_imm = 32'h4;
    step();
    check("srai_alu", 64'(ex_alu_control), 64'h9);
    check("srai_in2", 64'(ex_in2), 64'h4);
    id_funct3 = 3'b000;
    step();
    check("addi_alu", 64'(ex_alu_control), 64'h2);

    // Stall holds for 3 cycles while inputs change
    id_alu_op = 2'b00; id_rs1_data = 32'h1234_5678;
    step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      step();
      check("stall_hold_in1", 64'(ex_in1), 64'h1234_5678);
    end
    stall = 0;
    step();

    // Flush beats stall
    stall = 1; flush = 1; id_valid = 1; id_reg_write = 1;
    step();
    check("flush_valid", 64'(ex_valid), 64'h0);
    stall = 0; flush = 0;

    // Illegal funct3, then reset during stall
    id_valid = 1; id_alu_op = 2'b10; id_funct3 = 3'b010;
    step();
    check("ill_flag", 64'(ex_illegal), 64'h1);
    check("ill_alu", 64'(ex_alu_control), 64'h2);
    stall = 1; reset = 1;
    step();
    check("rst_valid", 64'(ex_valid), 64'h0);
    reset = 0; stall = 0; id_valid = 1;
    step();

    // Random traffic with occasional stall, flush and reset
    for (int i = 0; i < 400; i++) begin
      rand_id();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 29) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
